// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - stopwatch FSM with elapsed-time counter, lap bank and display steering
module stopwatch_lap_ctrl #(
    parameter int TIME_W = 24,
    parameter int LAP_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              view,
    output logic              running,
    output logic [TIME_W-1:0] time_cnt,
    output logic [LAP_AW:0]   lap_count,
    output logic [LAP_AW:0]   display_select,
    output logic [TIME_W-1:0] display_value,
    output logic              lap_overflow
);

    localparam int LAP_DEPTH = 1 << LAP_AW;
    localparam logic [LAP_AW:0] LAP_FULL = LAP_DEPTH[LAP_AW:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [LAP_AW:0]     lap_cnt_q, lap_cnt_d;
    logic [LAP_AW:0]     disp_sel_q, disp_sel_d;
    logic                ovf_q, ovf_d;
    logic                ss_prev_q, lap_prev_q, view_prev_q;
    logic [TIME_W-1:0]   lap_mem_q [LAP_DEPTH];
    logic [TIME_W-1:0]   lap_mem_d [LAP_DEPTH];

    logic ss_press, lap_press, view_press;
    logic [LAP_AW-1:0] rd_idx;

    assign ss_press   = start_stop & ~ss_prev_q;
    assign lap_press  = lap & ~lap_prev_q;
    assign view_press = view & ~view_prev_q;

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        lap_cnt_d  = lap_cnt_q;
        disp_sel_d = disp_sel_q;
        ovf_d      = ovf_q;
        lap_mem_d  = lap_mem_q;

        if (view_press && state_q != ST_IDLE) begin
            if (lap_cnt_q == '0 || disp_sel_q >= lap_cnt_q) begin
                disp_sel_d = '0;
            end else begin
                disp_sel_d = disp_sel_q + (LAP_AW+1)'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_press) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (tick && time_q != '1) begin
                    time_d = time_q + TIME_W'(1);
                end
                // start_stop outranks lap: a simultaneous lap press is dropped
                if (ss_press) begin
                    state_d = ST_PAUSED;
                end else if (lap_press) begin
                    if (lap_cnt_q != LAP_FULL) begin
                        lap_mem_d[lap_cnt_q[LAP_AW-1:0]] = time_q;
                        lap_cnt_d = lap_cnt_q + (LAP_AW+1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (ss_press) begin
                    state_d = ST_RUNNING;
                end else if (lap_press) begin
                    state_d    = ST_IDLE;
                    time_d     = '0;
                    lap_cnt_d  = '0;
                    disp_sel_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            time_q      <= '0;
            lap_cnt_q   <= '0;
            disp_sel_q  <= '0;
            ovf_q       <= 1'b0;
            ss_prev_q   <= 1'b0;
            lap_prev_q  <= 1'b0;
            view_prev_q <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            lap_cnt_q   <= lap_cnt_d;
            disp_sel_q  <= disp_sel_d;
            ovf_q       <= ovf_d;
            ss_prev_q   <= start_stop;
            lap_prev_q  <= lap;
            view_prev_q <= view;
            lap_mem_q   <= lap_mem_d;
        end
    end

    // display_select is 1-based; wrap of the low bits maps LAP_DEPTH onto the last slot
    assign rd_idx = disp_sel_q[LAP_AW-1:0] - LAP_AW'(1);

    assign running        = (state_q == ST_RUNNING);
    assign time_cnt       = time_q;
    assign lap_count      = lap_cnt_q;
    assign display_select = disp_sel_q;
    assign lap_overflow   = ovf_q;
    assign display_value  = (disp_sel_q == '0) ? time_q : lap_mem_q[rd_idx];

endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Parametrised stopwatch controller. It owns the elapsed-time counter and a bank of lap registers, and it steers the display between the live time and stored laps. It sits between the debounced push-button synchronisers and the display formatter. It generalises the earlier start/stop/lap FSM with these additions:
- a configurable counter width and lap depth;
- pause/resume;
- lap capture with overflow flagging;
- clear-from-pause.

## Interface
Parameters:
- TIME_W, 24, width of elapsed-time counter in ticks
- LAP_AW, 2, lap address width; LAP_DEPTH = 2**LAP_AW slots (legal LAP_AW 1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- tick  in  1  single-cycle time-base strobe (e.g. 100 Hz enable)
- start_stop  in  1  debounced level, already synchronous to clk; rising edge = press
- lap  in  1  debounced level; rising edge = press
- view  in  1  debounced level; rising edge = press
- running  out  1  high in RUNNING
- time_cnt  out  TIME_W  elapsed ticks
- lap_count  out  LAP_AW+1  valid stored laps, 0..LAP_DEPTH
- display_select  out  LAP_AW+1  0 = live time, k = lap k (1-based)
- display_value  out  TIME_W  time_cnt when display_select=0, else lap slot display_select-1
- lap_overflow  out  1  sticky; a lap press arrived while the bank was full

## Operation
- Edge detect: one prev register per button; press = in & ~prev. Prev registers reset to 0.
- States: IDLE, RUNNING, PAUSED. Reset enters IDLE.
- IDLE:
  - start_stop press -> RUNNING.
  - lap and view presses are ignored.
- RUNNING:
  - tick increments time_cnt, saturating at all-ones (no wrap).
  - start_stop press -> PAUSED.
  - lap press with lap_count < LAP_DEPTH: the current registered time_cnt (pre-increment) is written to slot lap_count, and lap_count increments.
  - lap press with the bank full: the capture is discarded and lap_overflow is set.
- PAUSED:
  - time_cnt holds.
  - start_stop press -> RUNNING (resume, count is kept).
  - lap press = clear: time_cnt, lap_count, display_select and lap_overflow go to 0, then -> IDLE. Lap slot contents need not be cleared.
- View press (RUNNING or PAUSED) advances display_select: 0 -> 1 -> ... -> lap_count -> 0. With lap_count = 0 it stays 0.
- display_value is a combinational mux on registered state. It updates in the same cycle as time_cnt or the lap memory changes.
- running is a decode of the state register.

## Timing
- Reset values:
  - state IDLE;
  - running, time_cnt, lap_count, display_select, lap_overflow all 0;
  - display_value 0.
- A button high at edge k with prev low is a press; the state and register updates are visible after edge k (1-cycle latency).
- A button held high produces exactly one press. It must return low for at least one cycle before it can produce another.
- Simultaneous events:
  - start_stop + lap in the same cycle: start_stop wins and lap is dropped. In RUNNING this means pause with no capture; in PAUSED it means resume with no clear.
  - tick + start_stop in RUNNING: the tick is counted and the pause takes effect.
  - tick + start_stop in PAUSED: the tick is not counted; counting starts on the next tick.
  - tick + lap in RUNNING: the slot gets the pre-increment value and time_cnt increments.
  - view is processed independently in the same cycle.
  - view + clear in PAUSED: clear wins and display_select = 0.
- rst asserted mid-run takes precedence over every input; all outputs are at reset values after that edge.
- Saturation: at all-ones time_cnt holds, and lap captures store all-ones.

## Test plan
- Reset, start_stop press, 5 ticks, start_stop press -> running 1 then 0, time_cnt = 5, state PAUSED, further ticks ignored.
- RUNNING with LAP_AW = 2: lap presses at time_cnt 3, 7, 9, 12, 15 -> slots hold 3, 7, 9, 12; lap_count = 4; lap_overflow = 1 after the fifth press.
- With 2 laps stored: 4 view presses -> display_select 1, 2, 0, 1; display_value tracks the slot contents; press with lap_count 0 -> stays 0.
- PAUSED at time_cnt 20 with 3 laps: lap press -> time_cnt 0, lap_count 0, display_select 0, lap_overflow 0, state IDLE, running 0.
- Same-cycle start_stop + lap in RUNNING -> PAUSED with lap_count unchanged. Same-cycle tick + lap at time_cnt 8 -> slot = 8, time_cnt = 9.
- TIME_W = 4, run 20 ticks -> time_cnt saturates at 15. start_stop held high for 10 cycles -> single state change. rst asserted mid-run -> all outputs 0 next cycle.
